private_ram_master: RTL and testbench

PRIVATE_RAM_MASTER -- requirements
Module: private_ram_master

---
 rtl/private_ram_master.sv | 110 +++++++++++
 tb/tb_private_ram_master.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/private_ram_master.sv
`default_nettype none
// ============================================================================
// Module      : private_ram_master
// Description : Single-initiator front end for a private RAM bank, with an
//               optional zero-fill after reset and a one-cycle response path.
// Revision    : 1.0 - initial release
// ============================================================================
module private_ram_master #(
   parameter int ADDR_WIDTH = 12,
   parameter bit INIT_ZERO  = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   output logic                  gnt_o,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  wen_i,
   input  logic [3:0]            be_i,
   input  logic [31:0]           wdata_i,
   output logic                  r_valid_o,
   output logic [31:0]           r_rdata_o,
   output logic                  init_done_o,
   output logic                  mem_csn_o,
   output logic                  mem_wen_o,
   output logic [3:0]            mem_be_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_wdata_o,
   input  logic [31:0]           mem_rdata_i
);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam state_e                RST_STATE = INIT_ZERO ? ST_INIT : ST_RUN;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   fill_q, fill_d;
   logic                    pend_q;
   logic                    rd_q;
   logic [31:0]             hold_q;
   logic                    rd_resp;

   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      gnt_o       = 1'b0;
      mem_csn_o   = 1'b1;
      mem_wen_o   = 1'b1;
      mem_be_o    = 4'h0;
      mem_addr_o  = '0;
      mem_wdata_o = 32'h0;
      if (!rst_i) begin
         case (state_q)
            ST_INIT: begin
               mem_csn_o  = 1'b0;
               mem_wen_o  = 1'b0;
               mem_be_o   = 4'hF;
               mem_addr_o = fill_q;
               // Counter parks on the last address so it never wraps to 0.
               if (fill_q == LAST_ADDR) begin
                  state_d = ST_RUN;
               end else begin
                  fill_d = fill_q + 1'b1;
               end
            end
            ST_RUN: begin
               gnt_o = req_i;
               if (req_i) begin
                  mem_csn_o   = 1'b0;
                  mem_wen_o   = wen_i;
                  mem_be_o    = be_i;
                  mem_addr_o  = addr_i;
                  mem_wdata_o = wdata_i;
               end
            end
            default: state_d = RST_STATE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RST_STATE;
         fill_q  <= '0;
         pend_q  <= 1'b0;
         rd_q    <= 1'b0;
         hold_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         pend_q  <= gnt_o;
         if (gnt_o) begin
            rd_q <= wen_i;
         end
         if (rd_resp) begin
            hold_q <= mem_rdata_i;
         end
      end
   end

   assign rd_resp     = pend_q && rd_q;
   assign r_valid_o   = pend_q && !rst_i;
   assign r_rdata_o   = rst_i ? 32'h0 : (rd_resp ? mem_rdata_i : hold_q);
   assign init_done_o = rst_i ? !INIT_ZERO : (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_private_ram_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_private_ram_master
// Description : Scoreboard bench for private_ram_master with a RAM bank model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_private_ram_master;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req = 1'b0;
   logic [AW-1:0] addr = '0;
   logic          wen = 1'b1;
   logic [3:0]    be = 4'hF;
   logic [31:0]   wdata = 32'h0;

   logic          gnt, rvalid, done, csn, mwen;
   logic [31:0]   rdata, mwdata, bank_rdata;
   logic [3:0]    mbe;
   logic [AW-1:0] maddr;

   logic          gnt0, rvalid0, done0, csn0, mwen0;
   logic [31:0]   rdata0, mwdata0;
   logic [3:0]    mbe0;
   logic [AW-1:0] maddr0;

   logic [31:0]   bank [16];
   logic [31:0]   sb [$];
   int            tests = 0;
   int            fails = 0;

   always #5 clk = ~clk;

   private_ram_master #(.ADDR_WIDTH(AW), .INIT_ZERO(1'b1)) u_dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr),
      .wen_i(wen), .be_i(be), .wdata_i(wdata), .r_valid_o(rvalid),
      .r_rdata_o(rdata), .init_done_o(done), .mem_csn_o(csn),
      .mem_wen_o(mwen), .mem_be_o(mbe), .mem_addr_o(maddr),
      .mem_wdata_o(mwdata), .mem_rdata_i(bank_rdata)
   );

   private_ram_master #(.ADDR_WIDTH(AW), .INIT_ZERO(1'b0)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt0), .addr_i(addr),
      .wen_i(wen), .be_i(be), .wdata_i(wdata), .r_valid_o(rvalid0),
      .r_rdata_o(rdata0), .init_done_o(done0), .mem_csn_o(csn0),
      .mem_wen_o(mwen0), .mem_be_o(mbe0), .mem_addr_o(maddr0),
      .mem_wdata_o(mwdata0), .mem_rdata_i(32'h0)
   );

   // Bank model: byte-masked writes, registered read data.
   initial begin
      for (int i = 0; i < 16; i++) bank[i] = 32'hA5A5A5A5;
      bank_rdata = 32'h0;
   end
   always @(posedge clk) begin
      if (csn === 1'b0) begin
         if (mwen === 1'b0) begin
            for (int b = 0; b < 4; b++)
               if (mbe[b]) bank[maddr][8*b +: 8] <= mwdata[8*b +: 8];
         end else begin
            bank_rdata <= bank[maddr];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Response monitor: every r_valid_o must match the oldest expectation.
   always @(negedge clk) begin
      if (rvalid === 1'b1) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_rvalid: got rdata %h expected no response", rdata);
         end else begin
            logic [31:0] e;
            e = sb.pop_front();
            if (rdata !== e) begin
               fails++;
               $display("FAIL resp_data: got %h expected %h", rdata, e);
            end
         end
      end
   end

   task automatic access(input logic w, input logic [AW-1:0] a, input logic [3:0] m,
                         input logic [31:0] d, input logic [31:0] exp);
      req = 1'b1; wen = w; addr = a; be = m; wdata = d;
      sb.push_back(exp);
      @(negedge clk);
      chk("gnt_run", {31'h0, gnt}, 32'h1);
      chk("bus_run", {21'h0, csn, mwen, mbe, maddr}, {21'h0, 1'b0, w, m, a});
      chk("bus_wdata", mwdata, d);
      @(posedge clk); #1;
   endtask

   task automatic idle(input logic [31:0] exp_hold);
      req = 1'b0; wen = 1'b1; addr = '0; be = 4'h0; wdata = 32'h0;
      @(negedge clk);
      chk("bus_idle", {gnt, csn, mwen, mbe, maddr}, {1'b0, 1'b1, 1'b1, 4'h0, 4'h0});
      chk("hold_idle", rdata, exp_hold);
      @(posedge clk); #1;
   endtask

   task automatic check_fill(input string tag);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if ({csn, mwen, mbe, maddr, gnt, done} !== {1'b0, 1'b0, 4'hF, i[AW-1:0], 1'b0, 1'b0}) begin
            tests++; fails++;
            $display("FAIL %s_fill[%0d]: got csn%b wen%b be%h addr%0d gnt%b done%b expected addr %0d write",
                     tag, i, csn, mwen, mbe, maddr, gnt, done, i);
         end else begin
            tests++;
         end
         if (i == 0) chk("fill_wdata", mwdata, 32'h0);
      end
      @(negedge clk);
      chk({tag, "_done_cycle17"}, {31'h0, done}, 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with request already pending at the initiator.
      req = 1'b1; wen = 1'b1; addr = '0; be = 4'hF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_outputs", {28'h0, gnt, rvalid, csn, done}, {28'h0, 1'b0, 1'b0, 1'b1, 1'b0});
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_done_nozero", {31'h0, done0}, 32'h1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("nozero_first_cycle", {30'h0, done0, gnt0}, 32'h3);
      @(posedge clk); #1;
      // Fill already began in the first cycle; re-align by resetting once more.
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_fill("init");
      chk("first_grant", {31'h0, gnt}, 32'h1);
      sb.push_back(32'h0);
      @(posedge clk); #1;

      access(1'b0, 4'd3, 4'b0101, 32'hDEADBEEF, 32'h0);
      access(1'b1, 4'd3, 4'hF,    32'h0,        32'h00AD00EF);
      access(1'b0, 4'd5, 4'hF,    32'h11111111, 32'h00AD00EF);
      access(1'b1, 4'd5, 4'hF,    32'h0,        32'h11111111);
      access(1'b0, 4'd6, 4'hF,    32'h22222222, 32'h11111111);
      idle(32'h11111111);
      idle(32'h11111111);
      idle(32'h11111111);
      access(1'b1, 4'd6, 4'hF,    32'h0,        32'h22222222);
      access(1'b1, 4'd3, 4'hF,    32'h0,        32'h00AD00EF);
      access(1'b1, 4'd9, 4'hF,    32'h0,        32'h0);
      idle(32'h0);

      // Read granted, then reset while its response is pending: discarded.
      req = 1'b1; wen = 1'b1; addr = 4'd3; be = 4'hF;
      @(posedge clk); #1;
      rst = 1'b1; req = 1'b0;
      @(negedge clk);
      chk("rst_pending_drop", {31'h0, rvalid}, 32'h0);
      chk("rst_mid_rdata", rdata, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      begin
         int n;
         n = 0;
         @(negedge clk);
         while (maddr !== 4'd9 && n < 40) begin
            n++;
            @(negedge clk);
         end
         chk("reach_fill9", {27'h0, (n < 40), maddr}, {27'h0, 1'b1, 4'd9});
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_fill("restart");
      chk("hold_after_rst", rdata, 32'h0);
      @(posedge clk); #1;
      idle(32'h0);

      chk("scoreboard_drained", sb.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
